// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes,
// default latencies and FSM state constants.
package md_pkg;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } md_op_e;

   localparam int MD_MULT_CYCLES_DEF = 5;
   localparam int MD_DIV_CYCLES_DEF  = 10;

   // The FSM state is derived from the cycle counter, not stored separately.
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   function automatic logic is_long_op(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic is_mult_op(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MULTU);
   endfunction

endpackage

// File: rtl/md_unit_if.sv
// Pipeline-facing signal bundle of the multiply/divide unit.
interface md_unit_if;

   logic        start;
   logic [2:0]  md_op;
   logic [31:0] a;
   logic [31:0] b;
   logic        md_use_d;
   logic        busy;
   logic        md_stall;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, md_op, a, b, md_use_d,
      input  busy, md_stall, hi, lo
   );

   modport slave (
      input  start, md_op, a, b, md_use_d,
      output busy, md_stall, hi, lo
   );

endinterface

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath producing {hi, lo} for one
// operation, including the divide-by-zero and signed-overflow cases.
module md_calc
   import md_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  md_op,
   output logic [63:0] res
);

   logic signed [31:0] sa;
   logic signed [31:0] sb;
   logic signed [31:0] s_quo;
   logic signed [31:0] s_rem;
   logic [31:0]        u_quo;
   logic [31:0]        u_rem;
   logic [63:0]        a_sx;
   logic [63:0]        b_sx;
   logic [63:0]        a_zx;
   logic [63:0]        b_zx;
   logic               div_by_zero;
   logic               div_ovf;

   assign sa = $signed(a);
   assign sb = $signed(b);

   // A 64-bit product of the extended operands keeps the right low 64 bits
   // for both signed and unsigned multiplies.
   assign a_sx = {{32{a[31]}}, a};
   assign b_sx = {{32{b[31]}}, b};
   assign a_zx = {32'd0, a};
   assign b_zx = {32'd0, b};

   assign s_quo = sa / sb;
   assign s_rem = sa % sb;
   assign u_quo = a / b;
   assign u_rem = a % b;

   assign div_by_zero = (b == 32'd0);
   assign div_ovf     = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

   always_comb begin
      res = 64'd0;
      case (md_op)
         MD_MULT:  res = a_sx * b_sx;
         MD_MULTU: res = a_zx * b_zx;
         MD_DIV: begin
            if (div_by_zero) begin
               res = {a, 32'hFFFF_FFFF};
            end else if (div_ovf) begin
               res = {32'd0, 32'h8000_0000};
            end else begin
               res = {s_rem, s_quo};
            end
         end
         MD_DIVU: begin
            if (div_by_zero) begin
               res = {a, 32'hFFFF_FFFF};
            end else begin
               res = {u_rem, u_quo};
            end
         end
         default: res = 64'd0;
      endcase
   end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: sequences multi-cycle ops on a down-counter,
// owns HI/LO and requests D-stage stalls while the unit is occupied.
module md_unit
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
   input  logic     clk,
   input  logic     reset,
   md_unit_if.slave bus
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   logic [CNT_W-1:0] cnt;
   logic             busy_q;
   logic [31:0]      hi_q;
   logic [31:0]      lo_q;
   logic [31:0]      res_hi;
   logic [31:0]      res_lo;
   logic [63:0]      calc_res;
   logic [0:0]       state;
   logic             accept;

   md_calc u_calc (
      .a     (bus.a),
      .b     (bus.b),
      .md_op (bus.md_op),
      .res   (calc_res)
   );

   assign state  = (cnt != '0) ? ST_RUN : ST_IDLE;
   assign accept = (state == ST_IDLE) && bus.start && is_long_op(bus.md_op);

   // The result is captured at acceptance and only copied into HI/LO on the
   // final busy edge, so HI/LO keep their old values for the whole run.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         busy_q <= 1'b0;
         hi_q   <= 32'd0;
         lo_q   <= 32'd0;
         res_hi <= 32'd0;
         res_lo <= 32'd0;
      end else if (state == ST_IDLE) begin
         if (accept) begin
            res_hi <= calc_res[63:32];
            res_lo <= calc_res[31:0];
            cnt    <= is_mult_op(bus.md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            busy_q <= 1'b1;
         end else if (bus.md_op == MD_MTHI) begin
            hi_q <= bus.a;
         end else if (bus.md_op == MD_MTLO) begin
            lo_q <= bus.a;
         end
      end else begin
         if (cnt == CNT_W'(1)) begin
            hi_q   <= res_hi;
            lo_q   <= res_lo;
            cnt    <= '0;
            busy_q <= 1'b0;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   // Stall is raised in the start cycle too, before busy has risen.
   assign bus.md_stall = bus.md_use_d & (bus.start | busy_q);
   assign bus.busy     = busy_q;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vector table, hand-written
// corner sequences and random ops against an arithmetic reference model.
module tb_md_unit;
   import md_pkg::*;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        use_d;
      logic [63:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   md_unit_if bus();

   md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference arithmetic on wide integers: divide magnitudes, then fix signs.
   function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb, q, r;
      longint unsigned ua, ub;
      logic [63:0]     res;
      res = 64'd0;
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      case (op)
         3'd1: res = sa * sb;
         3'd2: res = ua * ub;
         3'd3: begin
            if (b == 32'd0) begin
               res = {a, 32'hFFFF_FFFF};
            end else begin
               q = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
               r = (sa < 0 ? -sa : sa) % (sb < 0 ? -sb : sb);
               if ((sa < 0) != (sb < 0)) q = -q;
               if (sa < 0) r = -r;
               res = {r[31:0], q[31:0]};
            end
         end
         3'd4: begin
            if (b == 32'd0) begin
               res = {a, 32'hFFFF_FFFF};
            end else begin
               q = longint'(ua / ub);
               r = longint'(ua % ub);
               res = {r[31:0], q[31:0]};
            end
         end
         default: res = 64'd0;
      endcase
      return res;
   endfunction

   // Issues one long op at a negedge and follows it until busy drops.
   task automatic applyStimulus(input string name, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic use_d, input logic [63:0] exp);
      logic [31:0] old_hi;
      logic [31:0] old_lo;
      int          n;
      logic        stall_ok;
      logic        hold_ok;
      old_hi = bus.hi;
      old_lo = bus.lo;
      bus.start    = 1'b1;
      bus.md_op    = op;
      bus.a        = a;
      bus.b        = b;
      bus.md_use_d = use_d;
      #1 checkOutput({name, " stall_start"}, {63'd0, bus.md_stall}, {63'd0, use_d});
      @(negedge clk);
      bus.start = 1'b0;
      bus.md_op = MD_NONE;
      bus.a     = $urandom;
      bus.b     = $urandom;
      n        = 0;
      stall_ok = 1'b1;
      hold_ok  = 1'b1;
      while (bus.busy === 1'b1 && n < 40) begin
         n++;
         if (bus.md_stall !== use_d) stall_ok = 1'b0;
         if (bus.hi !== old_hi || bus.lo !== old_lo) hold_ok = 1'b0;
         @(negedge clk);
      end
      checkOutput({name, " busy_len"}, 64'(n), 64'((op <= 3'd2) ? MULT_N : DIV_N));
      checkOutput({name, " stall_busy"}, {63'd0, stall_ok}, 64'd1);
      checkOutput({name, " hilo_hold"}, {63'd0, hold_ok}, 64'd1);
      checkOutput({name, " stall_after"}, {63'd0, bus.md_stall}, 64'd0);
      checkOutput({name, " hilo"}, {bus.hi, bus.lo}, exp);
      bus.md_use_d = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic wait_not_busy(input string name);
      int n;
      n = 0;
      while (bus.busy === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
      checkOutput({name, " busy_drop"}, {63'd0, bus.busy}, 64'd0);
   endtask

   initial begin
      logic [63:0] exp;
      logic [31:0] ra, rb;
      logic [2:0]  rop;
      logic [63:0] hilo_before;

      vecs.push_back('{3'd1, 32'hFFFF_FFFE, 32'd3,         1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFA}});
      vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'd2,         1'b0, {32'h0000_0001, 32'hFFFF_FFFE}});
      vecs.push_back('{3'd3, 32'hFFFF_FFF9, 32'd2,         1'b0, {32'hFFFF_FFFF, 32'hFFFF_FFFD}});
      vecs.push_back('{3'd4, 32'h0000_1234, 32'd0,         1'b1, {32'h0000_1234, 32'hFFFF_FFFF}});
      vecs.push_back('{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h0000_0000, 32'h8000_0000}});
      vecs.push_back('{3'd3, 32'h0000_0005, 32'd0,         1'b0, {32'h0000_0005, 32'hFFFF_FFFF}});
      vecs.push_back('{3'd4, 32'd100,       32'd7,         1'b1, {32'd2,         32'd14}});
      vecs.push_back('{3'd3, 32'd7,         32'hFFFF_FFFE, 1'b0, {32'd1,         32'hFFFF_FFFD}});
      vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000});

      bus.start    = 1'b0;
      bus.md_op    = MD_NONE;
      bus.a        = 32'd0;
      bus.b        = 32'd0;
      bus.md_use_d = 1'b0;
      reset        = 1'b1;
      idle_cycles(3);
      reset = 1'b0;
      checkOutput("reset busy", {63'd0, bus.busy}, 64'd0);
      checkOutput("reset hilo", {bus.hi, bus.lo}, 64'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].use_d, vecs[i].exp);
      end

      // Undefined opcode and unqualified long ops must leave everything alone.
      hilo_before = {bus.hi, bus.lo};
      bus.start = 1'b1;
      bus.md_op = 3'd7;
      bus.a     = 32'h1111_1111;
      @(negedge clk);
      checkOutput("op7 busy", {63'd0, bus.busy}, 64'd0);
      bus.start = 1'b0;
      bus.md_op = MD_MULT;
      @(negedge clk);
      checkOutput("nostart busy", {63'd0, bus.busy}, 64'd0);
      checkOutput("noaction hilo", {bus.hi, bus.lo}, hilo_before);
      bus.md_op = MD_NONE;

      // mthi while busy is dropped; final hi is the product's high half.
      bus.start = 1'b1;
      bus.md_op = MD_MULT;
      bus.a     = 32'd3;
      bus.b     = 32'd5;
      @(negedge clk);
      bus.start = 1'b0;
      bus.md_op = MD_NONE;
      @(negedge clk);
      bus.md_op = MD_MTHI;
      bus.a     = 32'hAAAA_AAAA;
      @(negedge clk);
      bus.md_op = MD_NONE;
      wait_not_busy("mthi_busy");
      checkOutput("mthi_busy hilo", {bus.hi, bus.lo}, {32'd0, 32'd15});

      // Reset in the third busy cycle of a div aborts it and clears HI/LO.
      bus.md_op = MD_MTHI;
      bus.a     = 32'h55;
      @(negedge clk);
      bus.md_op = MD_MTLO;
      bus.a     = 32'h66;
      @(negedge clk);
      checkOutput("mthi_mtlo hilo", {bus.hi, bus.lo}, {32'h55, 32'h66});
      bus.start = 1'b1;
      bus.md_op = MD_DIV;
      bus.a     = 32'd100;
      bus.b     = 32'd3;
      @(negedge clk);
      bus.start = 1'b0;
      bus.md_op = MD_NONE;
      idle_cycles(2);
      checkOutput("abort busy_before", {63'd0, bus.busy}, 64'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("abort busy", {63'd0, bus.busy}, 64'd0);
      checkOutput("abort hilo", {bus.hi, bus.lo}, 64'd0);
      idle_cycles(DIV_N + 3);
      checkOutput("abort no_write", {bus.hi, bus.lo}, 64'd0);

      bus.md_op = MD_MTLO;
      bus.a     = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.md_op = MD_NONE;
      checkOutput("mtlo lo", {32'd0, bus.lo}, {32'd0, 32'hDEAD_BEEF});
      checkOutput("mtlo busy", {63'd0, bus.busy}, 64'd0);
      @(negedge clk);
      checkOutput("mtlo busy_later", {63'd0, bus.busy}, 64'd0);

      for (int i = 0; i < 25; i++) begin
         rop = 3'($urandom_range(1, 4));
         ra  = $urandom;
         case ($urandom_range(0, 7))
            0:       rb = 32'd0;
            1:       rb = 32'hFFFF_FFFF;
            2:       rb = 32'($urandom_range(1, 9));
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
         exp = ref_model(rop, ra, rb);
         applyStimulus($sformatf("rnd%0d", i), rop, ra, rb, 1'($urandom_range(0, 1)), exp);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the five-stage MIPS pipeline. It sits in the E stage beside the ALU and takes the same forwarded operands, `MFALUa` and `ALUb`. It sequences multi-cycle `mult`/`multu`/`div`/`divu` operations against a cycle counter, owns the HI/LO registers, and raises a stall request to the hazard unit whenever the D-stage instruction needs the unit while it is occupied.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`.

Ports:
- `clk`  in  1  clock. This is the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  the E-stage instruction is a multi-cycle MD op. Qualified by `md_op`.
- `md_op`  in  3  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo.
- `a`  in  32  rs operand, already forwarded.
- `b`  in  32  rt operand, already forwarded.
- `md_use_d`  in  1  the D-stage instruction is an MD op, mfhi/mflo or mthi/mtlo.
- `busy`  out  1  a multi-cycle operation is in progress.
- `md_stall`  out  1  stall request to the hazard unit. Combinational: `md_use_d & (start | busy)`.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- FSM states:
  - IDLE: `cnt == 0`.
  - RUN: `cnt != 0`.
  - `busy = (cnt != 0)`, registered.
- Accepting an operation, in IDLE with `start=1` and `md_op` in 1–4:
  - Compute the result from `a` and `b` and store it in `res_hi`/`res_lo`.
  - Load `cnt` with `MULT_CYCLES` (ops 1, 2) or `DIV_CYCLES` (ops 3, 4).
  - Go to RUN.
- RUN:
  - `cnt` decrements every cycle.
  - On the edge where `cnt == 1`: `hi<=res_hi`, `lo<=res_lo`, `cnt<=0`, return to IDLE.
- Arithmetic:
  - `mult`: signed 32×32→64. `multu`: unsigned 32×32→64. `{hi,lo}` = product.
  - `div`: `lo` = quotient, `hi` = remainder. Both signed, truncate toward zero; the remainder takes the sign of the dividend.
  - `divu`: the same, unsigned.
  - Divide by zero, both `div` and `divu`: `lo=32'hFFFF_FFFF`, `hi=a`.
  - `div` of 0x8000_0000 by 0xFFFF_FFFF: `lo=32'h8000_0000`, `hi=0`.
- `mthi`/`mtlo`, in IDLE only:
  - Write `a` into `hi` or `lo` on that edge.
  - No busy cycles.
- Any `start` or mthi/mtlo while `busy=1` is ignored. The hazard unit guarantees this never happens via `md_stall`. Verification flags it as an assertion.
- `md_op` 0, or `start=0` with `md_op` in 1–4: no action.
- Codes 7 and above: treated as none.

## Timing
- Reset values: `cnt=0`, `busy=0`, `hi=0`, `lo=0`, `res_hi=0`, `res_lo=0`.
- Reset asserted mid-operation aborts it. HI/LO are zeroed and the pending result is discarded.
- For a start accepted at edge t0:
  - `busy=1` in cycles t0+1 … t0+N.
  - The new `hi`/`lo` are visible after edge t0+N.
  - `busy=0` from t0+N onward.
- `md_stall` is high in the start cycle, even though `busy` is still 0. This covers an MD op in E followed by mfhi in D.
- Back-to-back: a new `start` is accepted on the same edge where `busy` drops, i.e. the edge where `cnt` goes 1→0? No. `busy` is still 1 during that cycle, so the earliest accepted start is the following edge, t0+N+1 relative to the first op's t0.
- `hi`/`lo` hold their old values throughout RUN. mfhi/mflo are stalled by `md_stall` and never read stale data.

## Structure
- Shared package `md_pkg`:
  - `md_op` encodings: `MD_NONE`, `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, `MD_MTHI`, `MD_MTLO`.
  - Default latency constants.
- One sub-module, `md_calc`: purely combinational. Takes `a`, `b` and `md_op`; returns the 64-bit `{res_hi, res_lo}` and applies all division boundary rules.
- The top level holds the counter/FSM, the result latch, HI/LO and the stall logic.

## Test plan
- `mult` with a=0xFFFF_FFFE (−2), b=3 → `busy` high for exactly 5 cycles; then hi=0xFFFF_FFFF, lo=0xFFFF_FFFA.
- `multu` with a=0xFFFF_FFFF, b=2 → hi=1, lo=0xFFFF_FFFE after 5 cycles.
- `div` with a=−7, b=2 → `busy` for 10 cycles; lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
- Division boundaries:
  - `divu` with b=0, a=0x1234 → lo=0xFFFF_FFFF, hi=0x1234.
  - `div` 0x8000_0000 / −1 → lo=0x8000_0000, hi=0.
- Stall and ignored writes:
  - mult start with `md_use_d=1` → `md_stall=1` in the start cycle and all 5 busy cycles, then 0.
  - mthi issued while busy → ignored; the final hi equals the product's high half.
- `reset` at busy cycle 3 of a `div` → the next cycle shows busy=0, hi=0, lo=0, and no later write.
- After reset, mtlo with a=0xDEAD_BEEF → lo=0xDEAD_BEEF on the next cycle, busy never asserts.
